core_gated_counter_mc: RTL

Multi-channel, window-timed successor to the single-channel gated counter. It counts events on N_CH asynchronous inputs over a programmable gate window of exactly GATE_LEN clock cycles. At window end it latches every channel's count and saturation flag simultaneously, then pulses `done`. It sits between the external photon/pulse inputs and the RTMQ readout registers and replaces externally timed rst/smp strobes with an internal gate timer.

---
 rtl/core_gated_counter_mc_pkg.sv | 13 +
 rtl/core_gated_counter_mc_ch.sv | 69 ++++++
 rtl/core_gated_counter_mc.sv | 108 ++++++++++
 3 files changed

// File: rtl/core_gated_counter_mc_pkg.sv
// rtl/core_gated_counter_mc_pkg.sv - shared state encoding and edge-mode constants
package core_gated_counter_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int EDGE_LEVEL = 0;
    localparam int EDGE_RISE  = 1;

endpackage

// File: rtl/core_gated_counter_mc_ch.sv
// rtl/core_gated_counter_mc_ch.sv - one count channel: synchroniser, edge detect, saturating counter
module core_gate_ch
    import core_gated_counter_mc_pkg::*;
#(
    parameter int W_CTR     = 16,
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [W_CTR-1:0] o_count,
    output logic             o_sat
);

    logic             r_s1;
    logic             r_s2;
    logic             w_evt;
    logic [W_CTR-1:0] r_count;
    logic             r_sat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
        end
    end

    generate
        if (EDGE_MODE == EDGE_RISE) begin : g_edge
            logic r_s3;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s3 <= 1'b0;
                end else begin
                    r_s3 <= r_s2;
                end
            end
            assign w_evt = r_s2 & ~r_s3;
        end else begin : g_level
            assign w_evt = r_s2;
        end
    endgenerate

    // An event that finds the counter at all-ones is lost, so remember it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_en && w_evt) begin
            if (&r_count) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + W_CTR'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule

// File: rtl/core_gated_counter_mc.sv
// rtl/core_gated_counter_mc.sv - multi-channel event counter over an internally timed gate window
module core_gated_counter_mc
    import core_gated_counter_mc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int W_CTR     = 16,
    parameter int W_GATE    = 24,
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_CH-1:0]         i_in,
    input  logic [W_GATE-1:0]       i_gate_len,
    input  logic                    i_start,
    input  logic                    i_abort,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [N_CH*W_CTR-1:0]   o_out,
    output logic [N_CH-1:0]         o_ovf
);

    state_t                r_state;
    state_t                w_next_state;
    logic [W_GATE-1:0]     r_timer;
    logic                  r_done;
    logic [N_CH*W_CTR-1:0] r_out;
    logic [N_CH-1:0]       r_ovf;
    logic [N_CH*W_CTR-1:0] w_cnt;
    logic [N_CH-1:0]       w_sat;
    logic                  w_clear;
    logic                  w_count_en;
    logic                  w_publish;

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_clear      = 1'b1;
                    w_next_state = (i_gate_len == '0) ? ST_LATCH : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_timer == W_GATE'(1)) begin
                    w_next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_next_state = ST_IDLE;
                w_publish    = !i_abort;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_count_en = (r_state == ST_COUNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_ovf   <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_publish;
            if (w_clear) begin
                r_timer <= i_gate_len;
            end else if (w_count_en) begin
                r_timer <= r_timer - W_GATE'(1);
            end
            if (w_publish) begin
                r_out <= w_cnt;
                r_ovf <= w_sat;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            core_gate_ch #(
                .W_CTR     (W_CTR),
                .EDGE_MODE (EDGE_MODE)
            ) u_ch (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_in    (i_in[gi]),
                .i_clear (w_clear),
                .i_en    (w_count_en),
                .o_count (w_cnt[gi*W_CTR +: W_CTR]),
                .o_sat   (w_sat[gi])
            );
        end
    endgenerate

    // The done cycle still counts as busy so the window is never seen as idle before results settle.
    assign o_busy = (r_state != ST_IDLE) | r_done;
    assign o_done = r_done;
    assign o_out  = r_out;
    assign o_ovf  = r_ovf;

endmodule
